seq_detector_prog: RTL and testbench

- Runtime-programmable serial bit-pattern detector; parametrised successor of the fixed 4-bit overlapping Mealy detector.
- Pattern length 1..MAX_LEN, overlapping or non-overlapping mode, valid-qualified input, Mealy match pulse plus registered copy.
- Saturating match counter.
- Sits after a serial deserialiser / line decoder; drives frame-sync and event logic.

---
 rtl/seq_det_pkg.sv | 30 +++
 rtl/sat_counter.sv | 28 ++
 rtl/seq_detector_prog.sv | 113 +++++++++++
 tb/tb_seq_detector_prog.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types and helpers for the programmable sequence detector
package seq_det_pkg;

    // Detector state: UNCFG until a legal configuration has been loaded.
    typedef enum logic {
        UNCFG = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Widest mask the helper can build; callers truncate to their own MAX_LEN.
    localparam int MASK_W = 64;

    // Width of the pattern-length field: must hold the value MAX_LEN itself.
    function automatic int calc_len_w(input int max_len);
        return $clog2(max_len) + 1;
    endfunction

    // Mask with the low 'len' bits set.
    function automatic logic [MASK_W-1:0] len_mask(input int len);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_W; i++) begin
            if (i < len) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
//
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   inc       count up by one (holds at all-ones)
//   clr       synchronous clear, wins over inc
//   value     current count
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] value
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/seq_detector_prog.sv
// rtl/seq_detector_prog.sv - runtime-programmable serial bit-pattern detector
//
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   in_valid     in_bit is sampled this cycle
//   in_bit       serial data bit
//   cfg_load     one-cycle pulse latching cfg_pattern / cfg_len / cfg_overlap
//   cfg_pattern  pattern, bit [cfg_len-1] received first, bit [0] last
//   cfg_len      pattern length, legal 1..MAX_LEN
//   cfg_overlap  1 = overlapping matches, 0 = non-overlapping
//   clr_count    synchronous clear of match_count
//   match        combinational match, same cycle as the final pattern bit
//   match_q      match delayed by one cycle
//   match_count  saturating count of matches
//   armed        a legal configuration is loaded
//   cfg_err      sticky, last cfg_load was illegal
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = calc_len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               clr_count,
    output logic               match,
    output logic               match_q,
    output logic [CNT_W-1:0]   match_count,
    output logic               armed,
    output logic               cfg_err
);

    state_t             state;
    logic [MAX_LEN-2:0] hist;
    logic [LEN_W-1:0]   fill;
    logic [MAX_LEN-1:0] pattern_r;
    logic [LEN_W-1:0]   len_r;
    logic               overlap_r;

    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;
    logic               cfg_legal;
    logic               fill_ok;
    logic               pat_eq;

    // Newest bit sits at window[0], matching pattern[0] as the last bit.
    assign window    = {hist, in_bit};
    assign mask      = MAX_LEN'(len_mask(int'(len_r)));
    assign cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    // fill counts bits held before this one; with in_bit we need len bits.
    assign fill_ok   = (fill + LEN_W'(1)) >= len_r;
    assign pat_eq    = ((window ^ pattern_r) & mask) == '0;

    assign match = (state == RUN) & in_valid & ~cfg_load & fill_ok & pat_eq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= UNCFG;
            hist      <= '0;
            fill      <= '0;
            pattern_r <= '0;
            len_r     <= '0;
            overlap_r <= 1'b0;
            match_q   <= 1'b0;
            armed     <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            match_q <= match;
            if (cfg_load) begin
                // The bit presented alongside cfg_load is always discarded.
                if (cfg_legal) begin
                    state     <= RUN;
                    pattern_r <= cfg_pattern;
                    len_r     <= cfg_len;
                    overlap_r <= cfg_overlap;
                    hist      <= '0;
                    fill      <= '0;
                    armed     <= 1'b1;
                    cfg_err   <= 1'b0;
                end else begin
                    cfg_err <= 1'b1;
                end
            end else if ((state == RUN) && in_valid) begin
                hist <= window[MAX_LEN-2:0];
                // Non-overlapping mode restarts matching by emptying fill;
                // stale history bits are then masked out by fill_ok.
                if (match && !overlap_r) begin
                    fill <= '0;
                end else if (fill != LEN_W'(MAX_LEN - 1)) begin
                    fill <= fill + LEN_W'(1);
                end
            end
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_count (
        .clk   (clk),
        .rst   (rst),
        .inc   (match),
        .clr   (clr_count),
        .value (match_count)
    );

endmodule

// File: tb/tb_seq_detector_prog.sv
// tb/tb_seq_detector_prog.sv - scoreboard testbench for seq_detector_prog
module tb_seq_detector_prog;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_bit = 1'b0;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               clr_count = 1'b0;
    logic               match;
    logic               match_q;
    logic [CNT_W-1:0]   match_count;
    logic               armed;
    logic               cfg_err;

    seq_detector_prog #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .clr_count   (clr_count),
        .match       (match),
        .match_q     (match_q),
        .match_count (match_count),
        .armed       (armed),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             m;
        logic             mq;
        logic [CNT_W-1:0] cnt;
        logic             arm;
        logic             err;
    } obs_t;

    obs_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: configuration plus the list of bits seen since it was loaded.
    bit       m_run;
    bit [7:0] m_pat;
    int       m_len;
    bit       m_ovl;
    bit       m_bits[$];
    int       m_since;
    bit       m_mq;
    int       m_cnt;
    bit       m_err;

    function automatic void model_reset();
        m_run = 0; m_pat = 0; m_len = 0; m_ovl = 0;
        m_bits.delete(); m_since = 0; m_mq = 0; m_cnt = 0; m_err = 0;
    endfunction

    // Last m_len bits received (this one included) equal the pattern, and at
    // least m_len bits have arrived since configuration or the last
    // non-overlapping match.
    function automatic bit model_hit(input bit v, input bit b, input bit ld);
        bit ok;
        if (!m_run || !v || ld || (m_since + 1 < m_len)) return 0;
        ok = 1;
        for (int k = 0; k < m_len; k++) begin
            bit got;
            got = (k == 0) ? b : m_bits[m_bits.size() - k];
            if (got != m_pat[k]) ok = 0;
        end
        return ok;
    endfunction

    task automatic cyc(input bit v, input bit b, input bit ld = 0,
                       input bit [7:0] p = 0, input bit [3:0] l = 0,
                       input bit o = 0, input bit clr = 0, input bit r = 0);
        obs_t e;
        bit   hit;
        @(posedge clk);
        #1;
        rst = r; in_valid = v; in_bit = b; cfg_load = ld;
        cfg_pattern = p; cfg_len = l; cfg_overlap = o; clr_count = clr;
        if (r) begin
            model_reset();
            e = '0;
        end else begin
            hit   = model_hit(v, b, ld);
            e.m   = hit;
            e.mq  = m_mq;
            e.cnt = CNT_W'(m_cnt);
            e.arm = m_run;
            e.err = m_err;
            m_mq  = hit;
            if (clr) m_cnt = 0;
            else if (hit && m_cnt < CNT_MAX) m_cnt++;
            if (ld) begin
                if (l >= 1 && l <= MAX_LEN) begin
                    m_run = 1; m_pat = p; m_len = int'(l); m_ovl = o;
                    m_bits.delete(); m_since = 0; m_err = 0;
                end else begin
                    m_err = 1;
                end
            end else if (m_run && v) begin
                m_bits.push_back(b);
                if (m_bits.size() > 16) void'(m_bits.pop_front());
                m_since++;
                if (hit && !m_ovl) m_since = 0;
            end
        end
        sb.push_back(e);
    endtask

    task automatic stream(input bit [15:0] bits, input int n, input bit gaps = 0);
        for (int i = n - 1; i >= 0; i--) begin
            cyc(1, bits[i]);
            if (gaps) cyc(0, $urandom_range(0, 1));
        end
    endtask

    initial begin : monitor
        obs_t e;
        obs_t a;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a = {match, match_q, match_count, armed, cfg_err};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL outputs t=%0t got m=%b mq=%b cnt=%0d armed=%b err=%b exp m=%b mq=%b cnt=%0d armed=%b err=%b",
                             $time, a.m, a.mq, a.cnt, a.arm, a.err, e.m, e.mq, e.cnt, e.arm, e.err);
                end
            end
        end
    end

    initial begin : driver
        bit [7:0] p;
        bit [3:0] l;
        int       r;
        int       waited;
        model_reset();
        cyc(0, 0, .r(1));
        cyc(0, 0, .r(1));
        cyc(1, 1);
        cyc(1, 0);
        // Overlapping 1011; the bit offered with cfg_load is dropped.
        cyc(1, 1, 1, 8'b0000_1011, 4, 1);
        stream(16'b1011011, 7);
        cyc(0, 0, .clr(1));
        // Non-overlapping 1011, then continue with 0,1,1.
        cyc(0, 0, 1, 8'b0000_1011, 4, 0);
        stream(16'b1011011011, 10);
        cyc(0, 0, .clr(1));
        // Overlapping with idle gaps between bits.
        cyc(0, 0, 1, 8'b0000_1011, 4, 1);
        stream(16'b1011011, 7, 1);
        // Illegal loads keep the old configuration alive.
        cyc(0, 0, 1, 8'hFF, 0, 0);
        cyc(1, 1, 1, 8'hFF, 9, 0);
        stream(16'b1011011, 7);
        cyc(0, 0, 1, 8'b0000_1011, 4, 1);
        cyc(0, 0, .clr(1));
        // len=1 saturation, then clear together with a match.
        cyc(0, 0, 1, 8'b0000_0001, 1, 0);
        stream(16'b111111, 6);
        cyc(1, 1, .clr(1));
        cyc(1, 1);
        // Reset in the middle of a pattern loses the configuration.
        cyc(0, 0, 1, 8'b0000_1011, 4, 1);
        stream(16'b101, 3);
        cyc(1, 1, .r(1));
        stream(16'b1011011, 7);
        cyc(0, 0, 1, 8'hA5, 8, 1);
        stream(16'b10100101, 8);
        cyc(0, 0);
        // Randomized traffic, short patterns favoured so matches are frequent.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 199);
            if (r < 2) begin
                cyc(0, 0, .r(1));
            end else if (r < 8) begin
                p = 8'($urandom);
                case ($urandom_range(0, 5))
                    0:       l = 4'($urandom_range(0, 1) ? 0 : $urandom_range(9, 15));
                    1:       l = 4'($urandom_range(5, 8));
                    default: l = 4'($urandom_range(1, 4));
                endcase
                cyc($urandom_range(0, 1), $urandom_range(0, 1), 1, p, l, $urandom_range(0, 1));
            end else begin
                cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1), 0, 0, 0, 0,
                    $urandom_range(0, 39) == 0);
            end
        end
        waited = 0;
        while (sb.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (sb.size() > 0) begin
            bad++;
            $display("FAIL drain left=%0d required=0", sb.size());
        end
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
